apb2_cmd_master: RTL and testbench

APB initiator (requester) for the APB2 peripheral domain. It converts a single-outstanding command/response handshake interface into compliant APB SETUP/ACCESS transfers toward the APB2 slave mux. It then returns read data and error status on a response channel. It sits between an AHB/DMA-side request source and the APB2 slave mux, driving the psel/penable/paddr/pwdata/pstrb/pprot/pwrite bus that the ethernet and advanced-timer slaves decode.

---
 rtl/apb2_cmd_master.sv | 105 ++++++++++
 tb/tb_apb2_cmd_master.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/apb2_cmd_master.sv
// apb2_cmd_master: command/response to APB SETUP/ACCESS initiator; optional ACCESS timeout under `APB2_MST_TIMEOUT_EN`
module apb2_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                apb2_root_clk,
  input  logic                apb2_root_rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_slverr,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic accept, done, abort;
  assign accept    = state == IDLE && cmd_valid;
  assign done      = state == ACCESS && pready;
  assign cmd_ready = state == IDLE;
  assign psel      = state == SETUP || state == ACCESS;
  assign penable   = state == ACCESS;
  assign rsp_valid = state == RESP;
`ifdef APB2_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  logic          timeout_q;
  assign abort       = state == ACCESS && !pready && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign rsp_timeout = timeout_q;
  // count stalled ACCESS cycles, restarting each time a new ACCESS is entered
  always_ff @(posedge apb2_root_clk) begin
    if (!apb2_root_rstn) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !pready && !abort) cnt <= cnt + 1'b1;
  end
  // timeout flag follows the outcome of the most recent transfer
  always_ff @(posedge apb2_root_clk) begin
    if (!apb2_root_rstn) timeout_q <= 1'b0;
    else if (done) timeout_q <= 1'b0;
    else if (abort) timeout_q <= 1'b1;
  end
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  // state register
  always_ff @(posedge apb2_root_clk) begin
    if (!apb2_root_rstn) state <= IDLE;
    else state <= state_nxt;
  end
  // next-state: one SETUP cycle, ACCESS until ready or abort, RESP until consumed
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = cmd_valid ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = (pready || abort) ? RESP : ACCESS;
      RESP:    state_nxt = rsp_ready ? IDLE : RESP;
    endcase
  end
  // bus fields load on accept and then hold; response fields load at completion
  always_ff @(posedge apb2_root_clk) begin
    if (!apb2_root_rstn) begin
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      pprot      <= '0;
      pwrite     <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      if (accept) begin
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
        pstrb  <= cmd_write ? cmd_strb : '0;
        pprot  <= cmd_prot;
        pwrite <= cmd_write;
      end
      if (done) begin
        rsp_rdata  <= pwrite ? '0 : prdata;
        rsp_slverr <= pslverr;
      end else if (abort) begin
        rsp_rdata  <= '0;
        rsp_slverr <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb2_cmd_master.sv
// tb_apb2_cmd_master: randomized transaction-level check of apb2_cmd_master against expected bus/response behaviour
module tb_apb2_cmd_master;
  localparam int TMO_N = 8;
`ifdef APB2_MST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic        clk = 1'b0, rstn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  apb2_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO_N)) dut (
    .apb2_root_clk(clk), .apb2_root_rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic junk_cmd();
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    cmd_prot  = 3'($urandom);
  endtask

  task automatic chk_bus(input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr);
    chk("paddr", paddr, a);
    chk("pwdata", pwdata, wd);
    chk("pstrb", 32'(pstrb), 32'(st));
    chk("pprot", 32'(pprot), 32'(pr));
    chk("pwrite", 32'(pwrite), 32'(w));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_psel"}, 32'(psel), 0);
    chk({tag, "_penable"}, 32'(penable), 0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_slverr"}, 32'(rsp_slverr), 0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_pstrb"}, 32'(pstrb), 0);
    chk({tag, "_pprot"}, 32'(pprot), 0);
    chk({tag, "_pwrite"}, 32'(pwrite), 0);
  endtask

  // one complete transfer starting at a negedge in IDLE, ending at a negedge back in IDLE
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int waits,
                      input int bp, input logic [31:0] rd, input bit err);
    bit tmo;
    int ncyc;
    logic [31:0] e_rdata;
    bit e_err;
    logic [3:0] e_strb;
    tmo     = TMO_EN && waits >= TMO_N;
    ncyc    = tmo ? TMO_N : waits + 1;
    e_rdata = (tmo || w) ? 32'h0 : rd;
    e_err   = tmo ? 1'b1 : err;
    e_strb  = w ? st : 4'h0;
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
    rsp_ready = 1'($urandom);
    @(negedge clk);
    junk_cmd();
    chk("setup_psel", 32'(psel), 1);
    chk("setup_penable", 32'(penable), 0);
    chk("setup_cmd_ready", 32'(cmd_ready), 0);
    chk_bus(w, a, wd, e_strb, pr);
    @(negedge clk);
    for (int i = 0; i < ncyc; i++) begin
      chk("access_psel", 32'(psel), 1);
      chk("access_penable", 32'(penable), 1);
      chk("access_rsp_valid", 32'(rsp_valid), 0);
      chk_bus(w, a, wd, e_strb, pr);
      junk_cmd();
      rsp_ready = 1'($urandom);
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : $urandom;
      pslverr = (i == waits) ? err : 1'($urandom);
      @(negedge clk);
    end
    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
    for (int j = 0; j <= bp; j++) begin
      chk("resp_rsp_valid", 32'(rsp_valid), 1);
      chk("resp_rdata", rsp_rdata, e_rdata);
      chk("resp_slverr", 32'(rsp_slverr), 32'(e_err));
      chk("resp_timeout", 32'(rsp_timeout), 32'(tmo));
      chk("resp_psel", 32'(psel), 0);
      chk("resp_penable", 32'(penable), 0);
      chk("resp_cmd_ready", 32'(cmd_ready), 0);
      junk_cmd();
      rsp_ready = (j == bp);
      cmd_valid = (j != bp);
      @(negedge clk);
    end
    chk("done_rsp_valid", 32'(rsp_valid), 0);
    chk("done_cmd_ready", 32'(cmd_ready), 1);
    chk("done_psel", 32'(psel), 0);
    chk_bus(w, a, wd, e_strb, pr);
    rsp_ready = 1'($urandom);
  endtask

  task automatic rst_mid();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40020020; cmd_prot = 3'h1;
    @(negedge clk);
    cmd_valid = 1'b0; pready = 1'b0;
    @(negedge clk);
    chk("mid_psel", 32'(psel), 1);
    chk("mid_penable", 32'(penable), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    rstn = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_psel", 32'(psel), 0);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    pready = 1'b0;
  endtask

  initial begin
    cmd_valid = 1'b1; junk_cmd();
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_reset_outs("reset");
    end
    rstn = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    xfer(1'b1, 32'h40021004, 32'hA5A50001, 4'hF, 3'h0, 0, 0, $urandom, 1'b0);
    xfer(1'b0, 32'h40020010, $urandom, 4'hF, 3'h2, 3, 0, 32'h12345678, 1'b1);
    xfer(1'b1, 32'h40020014, $urandom, 4'h5, 3'h3, 1, 5, $urandom, 1'b0);
    xfer(1'b0, 32'h40020018, $urandom, 4'hA, 3'h4, TMO_N - 1, 1, 32'hCAFEF00D, 1'b0);
    xfer(1'b0, 32'h4002001C, $urandom, 4'hF, 3'h5, 20, 2, 32'h0BADBEEF, 1'b0);
    for (int k = 0; k < 40; k++)
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), $urandom, 1'($urandom));
    rst_mid();
    xfer(1'b0, 32'h40021000, $urandom, 4'hF, 3'h7, 2, 0, 32'h87654321, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
